// File: rtl/addsub_arb.sv
// addsub_arb: round-robin arbitrated shared adder/subtractor feeding a one-entry result slot
// Ports: clk, rst_n (asynchronous, active-low)
//   req_valid[NREQ], req_ready[NREQ] (one-hot grant), req_a/req_b[NREQ*dw] (requester i at [i*dw +: dw]),
//   req_add_sub[NREQ] (1 = A+B, 0 = A-B)
//   rsp_valid, rsp_ready, rsp_result[dw], rsp_id (index of the producing requester)
// Define ADDSUB_ARB_OVF_EN to add rsp_ovf, the signed-overflow flag registered alongside rsp_result.
module addsub_arb #(
    parameter int dw = 8,
    parameter int NREQ = 2,
    localparam int iw = (NREQ > 2) ? $clog2(NREQ) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*dw-1:0] req_a,
    input  logic [NREQ*dw-1:0] req_b,
    input  logic [NREQ-1:0]    req_add_sub,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [dw-1:0]      rsp_result,
    output logic [iw-1:0]      rsp_id
`ifdef ADDSUB_ARB_OVF_EN
    ,
    output logic               rsp_ovf
`endif
);
    typedef enum logic {EMPTY, FULL} slot_t;
    slot_t         state, state_nxt;
    logic [iw-1:0] ptr, ptr_nxt, gnt_id;
    logic          grant, op_add;
    logic [dw-1:0] op_a, op_b, sum;
`ifdef ADDSUB_ARB_OVF_EN
    logic          ovf;
`endif
    // Scan from the farthest offset back towards ptr so the nearest valid requester wins.
    always_comb begin
        gnt_id = ptr;
        for (int j = NREQ - 1; j >= 0; j--)
            if (req_valid[iw'((int'(ptr) + j) % NREQ)]) gnt_id = iw'((int'(ptr) + j) % NREQ);
    end
    always_comb begin
        grant = (state == EMPTY || rsp_ready) && |req_valid;
        req_ready = grant ? (NREQ'(1) << gnt_id) : '0;
        op_a = req_a[gnt_id*dw +: dw];
        op_b = req_b[gnt_id*dw +: dw];
        op_add = req_add_sub[gnt_id];
        sum = op_add ? op_a + op_b : op_a - op_b;
        ptr_nxt = (gnt_id == iw'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
        state_nxt = grant ? FULL : (rsp_ready ? EMPTY : state);
`ifdef ADDSUB_ARB_OVF_EN
        ovf = op_add ? (op_a[dw-1] == op_b[dw-1]) && (sum[dw-1] != op_a[dw-1])
                     : (op_a[dw-1] != op_b[dw-1]) && (sum[dw-1] != op_a[dw-1]);
`endif
    end
    assign rsp_valid = state == FULL;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
            ptr <= '0;
            rsp_result <= '0;
            rsp_id <= '0;
`ifdef ADDSUB_ARB_OVF_EN
            rsp_ovf <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (grant) begin
                ptr <= ptr_nxt;
                rsp_result <= sum;
                rsp_id <= gnt_id;
`ifdef ADDSUB_ARB_OVF_EN
                rsp_ovf <= ovf;
`endif
            end
        end
    end
endmodule

// File: tb/tb_addsub_arb.sv
// tb_addsub_arb: directed vectors plus a cycle-by-cycle reference model for addsub_arb (dw=8, NREQ=2)
module tb_addsub_arb;
    localparam int NREQ = 2;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid, req_ready, req_add_sub;
    logic [15:0] req_a, req_b;
    logic        rsp_valid, rsp_ready;
    logic [7:0]  rsp_result;
    logic [0:0]  rsp_id;
`ifdef ADDSUB_ARB_OVF_EN
    logic        rsp_ovf;
`endif
    int checks = 0;
    int errors = 0;
    // reference model of the result slot
    logic        m_valid;
    logic [7:0]  m_res;
    int          m_id, m_ptr;
    logic        m_ovf;

    addsub_arb #(.dw(8), .NREQ(NREQ)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_add_sub(req_add_sub),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_id(rsp_id)
`ifdef ADDSUB_ARB_OVF_EN
        , .rsp_ovf(rsp_ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", n, $time, act, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic add);
        req_a[i*8 +: 8] = a;
        req_b[i*8 +: 8] = b;
        req_add_sub[i] = add;
    endtask

    // Which requester the spec says is granted now, or -1.
    function automatic int pick();
        if (m_valid && !rsp_ready) return -1;
        for (int j = 0; j < NREQ; j++)
            if (req_valid[(m_ptr + j) % NREQ]) return (m_ptr + j) % NREQ;
        return -1;
    endfunction

    function automatic int signed_val(input int k);
        int sa, sb;
        sa = int'($signed(req_a[k*8 +: 8]));
        sb = int'($signed(req_b[k*8 +: 8]));
        return req_add_sub[k] ? sa + sb : sa - sb;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int g;
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_res <= 8'h00;
            m_id <= 0;
            m_ptr <= 0;
            m_ovf <= 1'b0;
        end else begin
            g = pick();
            if (g >= 0) begin
                m_valid <= 1'b1;
                m_res <= 8'(signed_val(g));
                m_id <= g;
                m_ptr <= (g + 1) % NREQ;
                m_ovf <= (signed_val(g) > 127) || (signed_val(g) < -128);
            end else if (rsp_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        int g;
        g = pick();
        chk("model_req_ready", 32'(req_ready), (g < 0) ? 0 : (1 << g));
        chk("model_rsp_valid", 32'(rsp_valid), 32'(m_valid));
        if (m_valid) begin
            chk("model_rsp_result", 32'(rsp_result), 32'(m_res));
            chk("model_rsp_id", 32'(rsp_id), m_id);
`ifdef ADDSUB_ARB_OVF_EN
            chk("model_rsp_ovf", 32'(rsp_ovf), 32'(m_ovf));
`endif
        end
    end

    initial begin
        rst_n = 1'b0;
        rsp_ready = 1'b1;
        req_a = '0;
        req_b = '0;
        req_add_sub = '0;
        req_valid = 2'b11;
        set_req(0, 8'h10, 8'h01, 1'b1);
        set_req(1, 8'h20, 8'h05, 1'b0);
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 'h1);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_result", 32'(rsp_result), 0);
        chk("rst_rsp_id", 32'(rsp_id), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        // round robin, both requesters held, back-to-back results
        @(negedge clk); chk("rr_g0", 32'(req_ready), 'h1); chk("rr_v0", 32'(rsp_valid), 0);
        @(negedge clk); chk("rr_g1", 32'(req_ready), 'h2); chk("rr_r0", 32'(rsp_result), 'h11); chk("rr_i0", 32'(rsp_id), 0);
        @(negedge clk); chk("rr_g2", 32'(req_ready), 'h1); chk("rr_r1", 32'(rsp_result), 'h1B); chk("rr_i1", 32'(rsp_id), 1);
        @(negedge clk); chk("rr_g3", 32'(req_ready), 'h2); chk("rr_r2", 32'(rsp_result), 'h11); chk("rr_v2", 32'(rsp_valid), 1);
        @(posedge clk); #1 req_valid = 2'b00;
        @(negedge clk); chk("rr_r3", 32'(rsp_result), 'h1B); chk("rr_i3", 32'(rsp_id), 1);
        @(negedge clk); chk("rr_empty", 32'(rsp_valid), 0);
        // single add from requester 0
        @(posedge clk); #1 set_req(0, 8'h05, 8'h03, 1'b1); req_valid = 2'b01;
        @(negedge clk); chk("add_ready", 32'(req_ready), 'h1);
        @(posedge clk); #1 req_valid = 2'b00;
        @(negedge clk); chk("add_valid", 32'(rsp_valid), 1); chk("add_result", 32'(rsp_result), 'h08); chk("add_id", 32'(rsp_id), 0);
        // single subtract from requester 1
        @(posedge clk); #1 set_req(1, 8'h03, 8'h05, 1'b0); req_valid = 2'b10;
        @(negedge clk); chk("sub_ready", 32'(req_ready), 'h2);
        @(posedge clk); #1 req_valid = 2'b00;
        @(negedge clk); chk("sub_result", 32'(rsp_result), 'hFE); chk("sub_id", 32'(rsp_id), 1);
        // backpressure
        @(posedge clk); #1 rsp_ready = 1'b0; set_req(0, 8'h01, 8'h02, 1'b1); req_valid = 2'b01;
        @(negedge clk); chk("bp_first", 32'(req_ready), 'h1);
        @(posedge clk); #1 req_valid = 2'b11; set_req(1, 8'h09, 8'h04, 1'b0);
        repeat (3) begin
            @(negedge clk);
            chk("bp_ready", 32'(req_ready), 'h0);
            chk("bp_valid", 32'(rsp_valid), 1);
            chk("bp_result", 32'(rsp_result), 'h03);
            chk("bp_id", 32'(rsp_id), 0);
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(negedge clk); chk("bp_release", 32'(req_ready), 'h2); chk("bp_old", 32'(rsp_result), 'h03);
        @(posedge clk); #1 req_valid = 2'b00;
        @(negedge clk); chk("bp_new_result", 32'(rsp_result), 'h05); chk("bp_new_id", 32'(rsp_id), 1);
        // fill the slot with ptr left at 1, then withdraw an ungranted request
        @(posedge clk); #1 rsp_ready = 1'b0; set_req(0, 8'h7F, 8'h01, 1'b1); req_valid = 2'b01;
        @(negedge clk); chk("fill_ready", 32'(req_ready), 'h1);
        @(posedge clk); #1 req_valid = 2'b10;
        @(negedge clk); chk("hold_ready", 32'(req_ready), 'h0); chk("fill_result", 32'(rsp_result), 'h80);
`ifdef ADDSUB_ARB_OVF_EN
        chk("ovf_add", 32'(rsp_ovf), 1);
`endif
        @(posedge clk); #1 req_valid = 2'b00;
        // asynchronous reset while FULL
        @(negedge clk); #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(rsp_valid), 0);
        chk("arst_result", 32'(rsp_result), 0);
        chk("arst_id", 32'(rsp_id), 0);
        @(posedge clk); #1
        rsp_ready = 1'b1;
        set_req(0, 8'h80, 8'h01, 1'b0);
        set_req(1, 8'h10, 8'h20, 1'b1);
        req_valid = 2'b11;
        rst_n = 1'b1;
        @(negedge clk); chk("post_rst_grant", 32'(req_ready), 'h1);
        @(negedge clk); chk("post_rst_g1", 32'(req_ready), 'h2); chk("post_rst_r0", 32'(rsp_result), 'h7F);
`ifdef ADDSUB_ARB_OVF_EN
        chk("ovf_sub", 32'(rsp_ovf), 1);
`endif
        @(posedge clk); #1 req_valid = 2'b00;
        @(negedge clk); chk("post_rst_r1", 32'(rsp_result), 'h30); chk("post_rst_i1", 32'(rsp_id), 1);
`ifdef ADDSUB_ARB_OVF_EN
        chk("ovf_none", 32'(rsp_ovf), 0);
`endif
        @(negedge clk); chk("final_empty", 32'(rsp_valid), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
